// File: rtl/mips_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_md_pkg                                                     |
// | Brief    : Shared types and constants for the mult/div hazard controller   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips_md_pkg;

   typedef logic [1:0] mdState_t;

   localparam mdState_t c_IDLE = 2'd0;
   localparam mdState_t c_BUSY = 2'd1;
   localparam mdState_t c_WB   = 2'd2;

   localparam int c_MUL_LAT_DEF = 4;
   localparam int c_DIV_LAT_DEF = 32;

   // Minimum counter width able to hold max(mulLat, divLat) - 1.
   function automatic int cntWidth(input int mulLat, input int divLat);
      int maxLoad;
      maxLoad = ((mulLat > divLat) ? mulLat : divLat) - 1;
      if (maxLoad < 2)
         return 1;
      return $clog2(maxLoad + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_lat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : md_lat_counter                                                  |
// | Brief    : Loadable down-counter with zero flag, stops at zero             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module md_lat_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] loadVal,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Clear beats load beats decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (clr)
         r_cnt <= '0;
      else if (load)
         r_cnt <= loadVal;
      else if (dec && (r_cnt != '0))
         r_cnt <= r_cnt - c_ONE;
   end

   assign cnt  = r_cnt;
   assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/md_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : md_hazard_ctrl                                                  |
// | Brief    : Mult/div unit scheduler and HI/LO hazard stall generator.       |
// |            Define MD_STALL_PERF_EN to add the md_stall_cycles counter.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module md_hazard_ctrl
   import mips_md_pkg::*;
#(
   parameter int MUL_LAT = c_MUL_LAT_DEF,
   parameter int DIV_LAT = c_DIV_LAT_DEF,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_md_start,
   input  logic             ex_md_is_div,
   input  logic             ex_flush,
   input  logic             md_kill,
   input  logic             id_rd_hilo,
   input  logic             id_wr_hilo,
   input  logic             id_md_op,
   output logic             md_unit_start,
   output logic             md_hilo_we,
   output logic             md_busy,
   output logic             pipe_stall,
`ifdef MD_STALL_PERF_EN
   output logic [31:0]      md_stall_cycles,
`endif
   output logic [CNT_W-1:0] md_cnt
);

   localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LAT - 1);

   mdState_t         r_state;
   mdState_t         w_nextState;
   logic             w_accept;
   logic             w_cntZero;
   logic             w_cntClr;
   logic             w_cntDec;
   logic [CNT_W-1:0] w_loadVal;

   assign w_accept  = (r_state == c_IDLE) && ex_md_start && !ex_flush && !md_kill;
   assign w_loadVal = ex_md_is_div ? c_DIV_LOAD : c_MUL_LOAD;
   assign w_cntClr  = (r_state == c_BUSY) && md_kill;
   assign w_cntDec  = (r_state == c_BUSY);

   md_lat_counter #(
      .CNT_W (CNT_W)
   ) u_latCounter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_cntClr),
      .load    (w_accept),
      .loadVal (w_loadVal),
      .dec     (w_cntDec),
      .cnt     (md_cnt),
      .zero    (w_cntZero)
   );

   // Kill beats completion in BUSY; once in WB the result is committed.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE: if (w_accept) w_nextState = c_BUSY;
         c_BUSY: begin
            if (md_kill)
               w_nextState = c_IDLE;
            else if (w_cntZero)
               w_nextState = c_WB;
         end
         c_WB:    w_nextState = c_IDLE;
         default: w_nextState = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= c_IDLE;
      else
         r_state <= w_nextState;
   end

   assign md_unit_start = w_accept;
   assign md_hilo_we    = (r_state == c_WB);
   assign md_busy       = (r_state != c_IDLE);
   // WB is included so MFHI/MFLO leaves ID no earlier than HI/LO is written.
   assign pipe_stall    = md_busy && (id_rd_hilo || id_wr_hilo || id_md_op);

`ifdef MD_STALL_PERF_EN
   logic [31:0] r_stallCycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stallCycles <= '0;
      else if (pipe_stall && (r_stallCycles != 32'hFFFF_FFFF))
         r_stallCycles <= r_stallCycles + 32'd1;
   end

   assign md_stall_cycles = r_stallCycles;
`endif

endmodule
`default_nettype wire
